// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. It owns the PC and issues word reads over a
// req/gnt/rvalid memory port. Kept responses go into a small in-order FIFO
// that feeds decode through a valid/ready handshake. A redirect flushes the
// FIFO and turns every response still owed to the old stream into a discard.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [5:0]  if_opcode
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0] instr_mem [FIFO_DEPTH];
    logic [31:0] pc_mem    [FIFO_DEPTH];

    logic        req_xfer, rsp_ok, push, pop;
    logic [CW:0] credit_used;
    logic [31:0] redirect_base;
    logic        unused_redirect_lsb;

    assign redirect_base       = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Credit covers buffered entries plus in-flight requests (discards included),
    // so the FIFO can never be pushed while full.
    assign credit_used = {1'b0, count_q} + {1'b0, out_q};
    assign imem_req    = rst_n && (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc_q;

    assign req_xfer = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = imem_rvalid && (out_q != '0);
    assign pop      = if_valid && if_ready;
    assign push     = rsp_ok && !redirect_valid && (discard_q == '0);

    // Decode-facing outputs come from registered FIFO state only.
    assign if_valid  = (count_q != '0);
    assign if_instr  = if_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign if_pc     = if_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign if_opcode = if_instr[31:26];

    // Next-state for PCs, counters and FIFO pointers; redirect wins over all.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_d      = out_q + CW'(req_xfer) - CW'(rsp_ok);
        if (redirect_valid) begin
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            // Everything still in flight after this edge belongs to the old stream.
            discard_d  = out_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (req_xfer)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp_ok && (discard_q != '0))
                discard_d = discard_q - 1'b1;
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only visible through if_valid gating.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]    <= resp_pc_q;
        end
    end

endmodule
